// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg
//   Shared FSM encoding and shift-and-add-3 constants for the BCD converter.
//   Revision: 1.0  initial release
// ============================================================================
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam logic [3:0] BCD_SAT_DIGIT = 4'h9;
   localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
   localparam logic [3:0] ADJ_ADD       = 4'd3;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// bcd_digit_adjust
//   One BCD digit pre-shift correction: adds 3 when the digit is 5 or more.
//   Revision: 1.0  initial release
// ============================================================================
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Inputs never exceed 9, so the 4-bit sum cannot wrap.
   assign dout = (din >= ADJ_THRESHOLD) ? din + ADJ_ADD : din;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/bcd_converter.sv
`default_nettype none
// ============================================================================
// bcd_converter
//   Sequential binary-to-BCD converter (one bit per clock, MSB first) with
//   saturation on overflow. Define BCD_LZB_EN to enable leading-zero blanking.
//   Revision: 1.0  initial release
// ============================================================================
module bcd_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int                 c_cnt_w = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WIDTH-1:0]      r_shift;
   logic [4*DIGITS-1:0]   r_work;
   logic                  r_acc;
   logic [c_cnt_w-1:0]    r_count;
   logic [4*DIGITS-1:0]   r_bcd;
   logic                  r_ovf;

   logic [4*DIGITS-1:0]   w_adj;
   logic [4*DIGITS-1:0]   w_work_nxt;
   logic [WIDTH-1:0]      w_shift_nxt;
   logic                  w_acc_nxt;
   logic [4*DIGITS-1:0]   w_bcd_fin;
   logic                  w_last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (r_work[4*g +: 4]),
         .dout (w_adj[4*g +: 4])
      );
   end

   // The bit pushed out of the top digit means the value no longer fits.
   assign w_work_nxt  = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
   assign w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
   assign w_acc_nxt   = r_acc | w_adj[4*DIGITS-1];
   assign w_bcd_fin   = w_acc_nxt ? {DIGITS{BCD_SAT_DIGIT}} : w_work_nxt;
   assign w_last      = (r_count == c_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE:  if (start) w_state_nxt = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = FIN;
         end
         FIN: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Results are committed on the final shift so they are valid in the FIN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift <= '0;
         r_work  <= '0;
         r_acc   <= 1'b0;
         r_count <= '0;
         r_bcd   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_shift <= bin;
               r_work  <= '0;
               r_acc   <= 1'b0;
               r_count <= '0;
            end
            SHIFT: begin
               r_shift <= w_shift_nxt;
               r_work  <= w_work_nxt;
               r_acc   <= w_acc_nxt;
               r_count <= r_count + c_cnt_w'(1);
               if (w_last) begin
                  r_bcd <= w_bcd_fin;
                  r_ovf <= w_acc_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bcd      = r_bcd;
   assign overflow = r_ovf;

`ifdef BCD_LZB_EN
   logic [DIGITS-1:0] r_blank;
   logic [DIGITS-1:0] w_blank_fin;
   logic              w_zero_run;

   // Digit 0 is never blanked so a zero value still shows "0".
   always_comb begin
      w_blank_fin = '0;
      w_zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_run     = w_zero_run & (w_bcd_fin[4*i +: 4] == 4'd0);
         w_blank_fin[i] = w_zero_run & ~w_acc_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                            r_blank <= '0;
      else if ((r_state == SHIFT) && w_last) r_blank <= w_blank_fin;
   end

   assign blank = r_blank;
`else
   assign blank = '0;
`endif

endmodule : bcd_converter
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// ============================================================================
// tb_bcd_converter
//   Directed, table-driven self-checking bench for bcd_converter.
//   Revision: 1.0  initial release
// ============================================================================
module tb_bcd_converter;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 4;
   localparam int LAT    = WIDTH + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] bin;
   logic [15:0] bcd;
   logic        busy, done, overflow;
   logic [3:0]  blank;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bin      (bin),
      .bcd      (bcd),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .blank    (blank)
   );

   typedef struct {
      logic [31:0] bin;
      logic [15:0] bcd;
      logic        ovf;
      logic [3:0]  blank_lzb;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_blank(input logic [3:0] lzb);
`ifdef BCD_LZB_EN
      return lzb;
`else
      return 4'b0000;
`endif
   endfunction

   // One start pulse; reports the cycle done appeared (1 = cycle after accept).
   task automatic run_conv(input logic [31:0] v, output int lat, output int busy_cnt,
                           output logic held_ok, output logic [15:0] r_bcd,
                           output logic r_ovf, output logic [3:0] r_blank);
      logic [15:0] prev;
      prev     = bcd;
      lat      = -1;
      busy_cnt = 0;
      held_ok  = 1'b1;
      r_bcd    = 'x;
      r_ovf    = 1'bx;
      r_blank  = 'x;
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= LAT + 8; n++) begin
         if (n > 1) @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            lat     = n;
            r_bcd   = bcd;
            r_ovf   = overflow;
            r_blank = blank;
            break;
         end
         if (bcd !== prev) held_ok = 1'b0;
      end
      @(negedge clk);
      check("idle_after_done", {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int          lat, bcnt, ndone, first_n, second_n;
      logic        held;
      logic [15:0] rb, b1, b2;
      logic        ro;
      logic [3:0]  rbl;
      logic        quiet;

      vecs[0]  = '{32'd1234,       16'h1234, 1'b0, 4'b0000};
      vecs[1]  = '{32'd0,          16'h0000, 1'b0, 4'b1110};
      vecs[2]  = '{32'd9999,       16'h9999, 1'b0, 4'b0000};
      vecs[3]  = '{32'd10000,      16'h9999, 1'b1, 4'b0000};
      vecs[4]  = '{32'd57,         16'h0057, 1'b0, 4'b1100};
      vecs[5]  = '{32'd7,          16'h0007, 1'b0, 4'b1110};
      vecs[6]  = '{32'd100,        16'h0100, 1'b0, 4'b1000};
      vecs[7]  = '{32'd5000,       16'h5000, 1'b0, 4'b0000};
      vecs[8]  = '{32'd90,         16'h0090, 1'b0, 4'b1100};
      vecs[9]  = '{32'd1005,       16'h1005, 1'b0, 4'b0000};
      vecs[10] = '{32'hFFFF_FFFF,  16'h9999, 1'b1, 4'b0000};
      vecs[11] = '{32'd10,         16'h0010, 1'b0, 4'b1100};

      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {11'd0, bcd, busy, done, overflow, blank}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         run_conv(vecs[i].bin, lat, bcnt, held, rb, ro, rbl);
         check($sformatf("v%0d_latency", i), lat, LAT);
         check($sformatf("v%0d_busy_cycles", i), bcnt, LAT);
         check($sformatf("v%0d_bcd_held", i), {31'd0, held}, 32'd1);
         check($sformatf("v%0d_bcd", i), {16'd0, rb}, {16'd0, vecs[i].bcd});
         check($sformatf("v%0d_overflow", i), {31'd0, ro}, {31'd0, vecs[i].ovf});
         check($sformatf("v%0d_blank", i), {28'd0, rbl}, {28'd0, exp_blank(vecs[i].blank_lzb)});
      end

      // Start re-pulsed with a different bin during a conversion is ignored.
      ndone   = 0;
      first_n = -1;
      rb      = 'x;
      @(negedge clk);
      start = 1'b1;
      bin   = 32'd1234;
      for (int n = 1; n <= 70; n++) begin
         @(negedge clk);
         start = (n == 5) || (n == 20);
         if (n == 5 || n == 20) bin = 32'd42;
         if (done) begin
            ndone++;
            if (first_n < 0) begin
               first_n = n;
               rb      = bcd;
            end
         end
      end
      start = 1'b0;
      check("restart_done_count", ndone, 1);
      check("restart_latency", first_n, LAT);
      check("restart_bcd", {16'd0, rb}, 32'h1234);

      // Start held high: back-to-back conversions 34 cycles apart.
      ndone    = 0;
      first_n  = -1;
      second_n = -1;
      b1       = 'x;
      b2       = 'x;
      @(negedge clk);
      start = 1'b1;
      bin   = 32'd7;
      for (int n = 1; n <= 90; n++) begin
         @(negedge clk);
         if (n == 2)  bin = 32'd8;
         if (n == 35) start = 1'b0;
         if (done) begin
            ndone++;
            if (ndone == 1) begin first_n = n;  b1 = bcd; end
            if (ndone == 2) begin second_n = n; b2 = bcd; end
         end
      end
      start = 1'b0;
      check("held_done_count", ndone, 2);
      check("held_first_latency", first_n, LAT);
      check("held_interval", second_n - first_n, LAT + 1);
      check("held_first_bcd", {16'd0, b1}, 32'h0007);
      check("held_second_bcd", {16'd0, b2}, 32'h0008);

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      start = 1'b1;
      bin   = 32'd1234;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_outputs", {11'd0, bcd, busy, done, overflow, blank}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      quiet = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done || busy) quiet = 1'b0;
      end
      check("midreset_no_done", {31'd0, quiet}, 32'd1);
      run_conv(32'd999, lat, bcnt, held, rb, ro, rbl);
      check("after_reset_latency", lat, LAT);
      check("after_reset_bcd", {16'd0, rb}, 32'h0999);
      check("after_reset_overflow", {31'd0, ro}, 32'd0);
      check("after_reset_blank", {28'd0, rbl}, {28'd0, exp_blank(4'b1000)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bcd_converter
`default_nettype wire
